// File: rtl/icache_fetch_responder_if.sv
// Bundle of icache fill-request and RAM-port signals seen by the fetch responder.
// The slave modport is the responder's view; master is the surrounding caches and RAM.
interface icache_fetch_responder_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0][31:0] iload;
    logic                  dbusy;
    logic                  ramREN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;
    logic                  ibusy;
    logic [7:0]            err_cnt;

    modport slave (
        input  iREN, iaddr, dbusy, ramload, ramstate,
        output iwait, iload, ramREN, ramaddr, ibusy, err_cnt
    );

    modport master (
        output iREN, iaddr, dbusy, ramload, ramstate,
        input  iwait, iload, ramREN, ramaddr, ibusy, err_cnt
    );
endinterface

// File: rtl/icache_fetch_responder.sv
// Round-robin instruction-fill responder: grants one icache at a time a single-word
// RAM read, yields to the data side on dbusy, and counts RAM error cycles.
module icache_fetch_responder #(
    parameter int CPUS    = 2,
    parameter int CPUID_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input logic                      CLK,
    input logic                      nRST,
    icache_fetch_responder_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    state_e               state_q;
    logic [CPUID_W-1:0]   rr_ptr_q;
    logic [CPUID_W-1:0]   gnt_q;
    logic [31:0]          lat_addr_q;
    logic [7:0]           err_cnt_q;

    logic                 arb_found;
    logic [CPUID_W-1:0]   arb_idx;
    logic [CPUID_W:0]     arb_sum;
    logic                 in_req;
    logic                 req_abort;
    logic                 req_done;
    logic                 req_err;
    logic [CPUID_W-1:0]   gnt_next;

    // Scan from the far end back toward rr_ptr so the nearest requester wins last.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            arb_sum = {1'b0, rr_ptr_q} + (CPUID_W + 1)'(k);
            if (arb_sum >= (CPUID_W + 1)'(CPUS))
                arb_sum = arb_sum - (CPUID_W + 1)'(CPUS);
            if (bus.iREN[arb_sum[CPUID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[CPUID_W-1:0];
            end
        end
    end

    // A redirected PC or dropped request makes the in-flight word useless to the core.
    assign in_req    = (state_q == REQ);
    assign req_abort = bus.dbusy || !bus.iREN[gnt_q] || (bus.iaddr[gnt_q] != lat_addr_q);
    assign req_done  = in_req && !req_abort && (bus.ramstate == RAM_ACCESS);
    assign req_err   = in_req && !req_abort && (bus.ramstate == RAM_ERROR);
    assign gnt_next  = (gnt_q == CPUID_W'(CPUS - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        bus.iwait = '1;
        bus.iload = '0;
        if (req_done) begin
            bus.iwait[gnt_q] = 1'b0;
            bus.iload[gnt_q] = bus.ramload;
        end
    end

    assign bus.ramREN  = in_req && !req_abort;
    assign bus.ramaddr = in_req ? lat_addr_q : 32'h0;
    assign bus.ibusy   = in_req;
    assign bus.err_cnt = err_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            lat_addr_q <= 32'h0;
            err_cnt_q  <= 8'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.dbusy && arb_found) begin
                        gnt_q      <= arb_idx;
                        lat_addr_q <= bus.iaddr[arb_idx];
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (req_abort) begin
                        state_q <= IDLE;
                    end else if (req_done) begin
                        rr_ptr_q <= gnt_next;
                        state_q  <= IDLE;
                    end else if (req_err && err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'h1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder with two cores: a per-cycle vector table
// plus hand-written error-saturation and mid-request reset sequences.
module tb_icache_fetch_responder;

    localparam logic [1:0] FREE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] ERR  = 2'b11;

    logic CLK;
    logic nRST;

    icache_fetch_responder_if #(.CPUS(2)) bus ();

    icache_fetch_responder #(.CPUS(2), .CPUID_W(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  ren;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        db;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [1:0]  wt_e;
        logic [31:0] ld0_e;
        logic [31:0] ld1_e;
        logic        ren_e;
        logic [31:0] addr_e;
        logic        busy_e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic [1:0] ren, input logic [31:0] a0, input logic [31:0] a1,
        input logic db, input logic [1:0] rs, input logic [31:0] rl,
        input logic [1:0] wt_e, input logic [31:0] ld0_e, input logic [31:0] ld1_e,
        input logic ren_e, input logic [31:0] addr_e, input logic busy_e);
        vec_t v;
        v.ren = ren;   v.a0 = a0;       v.a1 = a1;       v.db = db;
        v.rs = rs;     v.rl = rl;       v.wt_e = wt_e;   v.ld0_e = ld0_e;
        v.ld1_e = ld1_e; v.ren_e = ren_e; v.addr_e = addr_e; v.busy_e = busy_e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ren, input logic [31:0] a0, input logic [31:0] a1,
                         input logic db, input logic [1:0] rs, input logic [31:0] rl);
        bus.iREN     = ren;
        bus.iaddr[0] = a0;
        bus.iaddr[1] = a1;
        bus.dbusy    = db;
        bus.ramstate = rs;
        bus.ramload  = rl;
    endtask

    initial begin
        // Test 2: single fetch, BUSY x3 then ACCESS
        vecs.push_back(mk(2'b01, 32'h40, 32'h0, 0, BUSY, 32'h0,        2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b01, 32'h40, 32'h0, 0, BUSY, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1));
        vecs.push_back(mk(2'b01, 32'h40, 32'h0, 0, BUSY, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1));
        vecs.push_back(mk(2'b01, 32'h40, 32'h0, 0, BUSY, 32'h0,        2'b11, 0, 0, 1, 32'h40, 1));
        vecs.push_back(mk(2'b01, 32'h40, 32'h0, 0, ACC,  32'h2001_0004, 2'b10, 32'h2001_0004, 0, 1, 32'h40, 1));
        vecs.push_back(mk(2'b00, 32'h44, 32'h0, 0, FREE, 32'h0,        2'b11, 0, 0, 0, 32'h0, 0));
        // core1 fetch brings rr_ptr back to 0
        vecs.push_back(mk(2'b10, 32'h44, 32'h100, 0, ACC, 32'hAAAA,    2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b10, 32'h44, 32'h100, 0, ACC, 32'h1111_1111, 2'b01, 0, 32'h1111_1111, 1, 32'h100, 1));
        // Test 3: contention alternates 0,1,0,1
        vecs.push_back(mk(2'b11, 32'h44, 32'h104, 0, ACC, 32'h5,       2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b11, 32'h44, 32'h104, 0, ACC, 32'h44,      2'b10, 32'h44, 0, 1, 32'h44, 1));
        vecs.push_back(mk(2'b11, 32'h48, 32'h104, 0, ACC, 32'h6,       2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b11, 32'h48, 32'h104, 0, ACC, 32'h104,     2'b01, 0, 32'h104, 1, 32'h104, 1));
        vecs.push_back(mk(2'b11, 32'h48, 32'h108, 0, ACC, 32'h7,       2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b11, 32'h48, 32'h108, 0, ACC, 32'h48,      2'b10, 32'h48, 0, 1, 32'h48, 1));
        vecs.push_back(mk(2'b11, 32'h4C, 32'h108, 0, ACC, 32'h8,       2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b11, 32'h4C, 32'h108, 0, ACC, 32'h108,     2'b01, 0, 32'h108, 1, 32'h108, 1));
        // Test 4: PC redirect abort on core1
        vecs.push_back(mk(2'b10, 32'h4C, 32'h100, 0, BUSY, 32'h0,      2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b10, 32'h4C, 32'h100, 0, BUSY, 32'h0,      2'b11, 0, 0, 1, 32'h100, 1));
        vecs.push_back(mk(2'b10, 32'h4C, 32'h200, 0, BUSY, 32'h0,      2'b11, 0, 0, 0, 32'h100, 1));
        vecs.push_back(mk(2'b10, 32'h4C, 32'h200, 0, BUSY, 32'h0,      2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b10, 32'h4C, 32'h200, 0, ACC, 32'h2222_2222, 2'b01, 0, 32'h2222_2222, 1, 32'h200, 1));
        // Test 5: dbusy aborts and holds off core0
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 0, BUSY, 32'h0,      2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 0, BUSY, 32'h0,      2'b11, 0, 0, 1, 32'h80, 1));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 1, ACC, 32'h9999_9999, 2'b11, 0, 0, 0, 32'h80, 1));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 1, ACC, 32'h9999_9999, 2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 1, ACC, 32'h9999_9999, 2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 0, ACC, 32'h9999_9999, 2'b11, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(2'b01, 32'h80, 32'h200, 0, ACC, 32'h3333_3333, 2'b10, 32'h3333_3333, 0, 1, 32'h80, 1));
        vecs.push_back(mk(2'b00, 32'h84, 32'h200, 0, FREE, 32'h0,      2'b11, 0, 0, 0, 32'h0, 0));

        nRST = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 1'b0, FREE, 32'h0);
        #1;
        check("reset.iwait",   32'(bus.iwait),   32'h3);
        check("reset.ramREN",  32'(bus.ramREN),  32'h0);
        check("reset.ramaddr", bus.ramaddr,      32'h0);
        check("reset.ibusy",   32'(bus.ibusy),   32'h0);
        check("reset.err_cnt", 32'(bus.err_cnt), 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ren, vecs[i].a0, vecs[i].a1, vecs[i].db, vecs[i].rs, vecs[i].rl);
            @(negedge CLK);
            check($sformatf("v%0d.iwait", i),   32'(bus.iwait),   32'(vecs[i].wt_e));
            check($sformatf("v%0d.iload0", i),  bus.iload[0],     vecs[i].ld0_e);
            check($sformatf("v%0d.iload1", i),  bus.iload[1],     vecs[i].ld1_e);
            check($sformatf("v%0d.ramREN", i),  32'(bus.ramREN),  32'(vecs[i].ren_e));
            check($sformatf("v%0d.ramaddr", i), bus.ramaddr,      vecs[i].addr_e);
            check($sformatf("v%0d.ibusy", i),   32'(bus.ibusy),   32'(vecs[i].busy_e));
            check($sformatf("v%0d.err_cnt", i), 32'(bus.err_cnt), 32'h0);
            @(posedge CLK); #1;
        end

        // Test 6: 300 ERROR cycles saturate err_cnt, then ACCESS completes
        drive(2'b01, 32'hC0, 32'h200, 1'b0, ERR, 32'h0);
        @(negedge CLK);
        check("err.idle_ramREN", 32'(bus.ramREN), 32'h0);
        @(posedge CLK); #1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (i == 0)   check("err.ramREN", 32'(bus.ramREN), 32'h1);
            if (i == 100) check("err.cnt100", 32'(bus.err_cnt), 32'd100);
            if (i == 299) check("err.iwait",  32'(bus.iwait),  32'h3);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        check("err.saturated", 32'(bus.err_cnt), 32'd255);
        drive(2'b01, 32'hC0, 32'h200, 1'b0, ACC, 32'h4444_4444);
        #1;
        check("err.fill_iwait", 32'(bus.iwait),   32'h2);
        check("err.fill_iload", bus.iload[0],     32'h4444_4444);
        check("err.fill_cnt",   32'(bus.err_cnt), 32'd255);
        @(posedge CLK); #1;

        // Test 1: reset asserted mid-REQ with RAM BUSY
        drive(2'b01, 32'hD0, 32'h200, 1'b0, BUSY, 32'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst.pre_ramREN",  32'(bus.ramREN), 32'h1);
        check("rst.pre_ramaddr", bus.ramaddr,     32'hD0);
        #2;
        nRST = 1'b0;
        #1;
        check("rst.ramREN",  32'(bus.ramREN),  32'h0);
        check("rst.iwait",   32'(bus.iwait),   32'h3);
        check("rst.err_cnt", 32'(bus.err_cnt), 32'h0);
        check("rst.ibusy",   32'(bus.ibusy),   32'h0);
        check("rst.ramaddr", bus.ramaddr,      32'h0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check("rst.idle_ibusy",  32'(bus.ibusy),  32'h0);
        check("rst.idle_ramREN", 32'(bus.ramREN), 32'h0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst.regrant_ramREN", 32'(bus.ramREN), 32'h1);
        check("rst.regrant_addr",   bus.ramaddr,     32'hD0);
        drive(2'b00, 32'hD0, 32'h200, 1'b0, FREE, 32'h0);
        @(posedge CLK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
